cmp_run_monitor: RTL and testbench

Parametrised, synthesisable run monitor for the N-node CMP. It observes each node's instruction-fetch and PC buses and detects per-node program completion (halt instruction fetched). It counts run cycles and per-node PC-stall cycles, then drains a fixed number of cycles before flagging done. A timeout watchdog covers runs that never halt. It sits beside the cmp top, tapping the nodeN_inst_in / nodeN_pc_out buses, and replaces bench-side wait/cycle-count logic so runs can be measured on silicon or in gate-level simulation.

---
 rtl/cmp_run_monitor.sv | 178 +++++++++++++++++
 tb/tb_cmp_run_monitor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_run_monitor.sv
// cmp_run_monitor
// Observes the per-node instruction-fetch and PC buses of the N-node CMP.
// It detects per-node program completion (a fetch of HALT_INST) and counts
// run cycles and per-node PC-stall cycles. Once every participating node has
// halted, it drains a fixed number of cycles before flagging done. A watchdog
// ends runs that never halt by entering TIMEOUT.
// Packed node vectors use an ascending range, so node 0 sits at the MSB end.

module cmp_run_monitor #(
    parameter int unsigned            NODES     = 4,
    parameter int unsigned            PC_W      = 32,
    parameter int unsigned            INST_W    = 32,
    parameter int unsigned            CNT_W     = 32,
    parameter logic [INST_W-1:0]      HALT_INST = INST_W'(32'h00000000),
    parameter int unsigned            DRAIN     = 5,
    parameter int unsigned            TIMEOUT   = 100000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic                      clear,
    input  logic [0:NODES-1]          node_mask,
    input  logic [0:NODES*INST_W-1]   inst_in,
    input  logic [0:NODES*PC_W-1]     pc_in,
    output logic [2:0]                state,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [0:NODES-1]          node_done,
    output logic [0:NODES*CNT_W-1]    node_cycle,
    output logic [0:NODES*CNT_W-1]    stall_count,
    output logic                      done,
    output logic                      timeout
);

    // The drain counter only has to hold DRAIN-1.
    localparam int unsigned DRN_W = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t              state_r;
    logic [0:NODES-1]    mask_r;
    logic                prev_valid_r;
    logic [PC_W-1:0]     prev_pc_r [NODES];
    logic [DRN_W-1:0]    drain_cnt_r;

    logic [0:NODES-1]    halt_s;
    logic [0:NODES-1]    stall_s;
    logic [0:NODES-1]    done_next_s;
    logic                all_done_s;

    assign state = state_r;

    // Per-node halt and stall detection for the current RUN edge
    always_comb begin
        halt_s      = {NODES{1'b0}};
        stall_s     = {NODES{1'b0}};
        done_next_s = {NODES{1'b0}};
        for (int i = 0; i < NODES; i++) begin
            halt_s[i]      = mask_r[i] & ~node_done[i] &
                             (inst_in[i*INST_W +: INST_W] == HALT_INST);
            stall_s[i]     = prev_valid_r & mask_r[i] & ~node_done[i] &
                             (pc_in[i*PC_W +: PC_W] == prev_pc_r[i]);
            done_next_s[i] = node_done[i] | halt_s[i];
        end
        // Masked-off nodes count as finished, so an empty mask drains at once.
        all_done_s = &(done_next_s | ~mask_r);
    end

    // Run-control FSM with its counters, capture registers and status flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            cycle_count  <= {CNT_W{1'b0}};
            node_done    <= {NODES{1'b0}};
            node_cycle   <= {(NODES*CNT_W){1'b0}};
            stall_count  <= {(NODES*CNT_W){1'b0}};
            mask_r       <= {NODES{1'b0}};
            prev_valid_r <= 1'b0;
            drain_cnt_r  <= {DRN_W{1'b0}};
            done         <= 1'b0;
            timeout      <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                prev_pc_r[i] <= {PC_W{1'b0}};
            end
        end else if (clear) begin
            // Soft return to IDLE; clear outranks a coincident start.
            state_r      <= ST_IDLE;
            cycle_count  <= {CNT_W{1'b0}};
            node_done    <= {NODES{1'b0}};
            node_cycle   <= {(NODES*CNT_W){1'b0}};
            stall_count  <= {(NODES*CNT_W){1'b0}};
            mask_r       <= {NODES{1'b0}};
            prev_valid_r <= 1'b0;
            drain_cnt_r  <= {DRN_W{1'b0}};
            done         <= 1'b0;
            timeout      <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                prev_pc_r[i] <= {PC_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_RUN;
                        cycle_count  <= {CNT_W{1'b0}};
                        node_done    <= {NODES{1'b0}};
                        node_cycle   <= {(NODES*CNT_W){1'b0}};
                        stall_count  <= {(NODES*CNT_W){1'b0}};
                        mask_r       <= node_mask;
                        prev_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    cycle_count  <= cycle_count + CNT_W'(1);
                    prev_valid_r <= 1'b1;
                    for (int i = 0; i < NODES; i++) begin
                        prev_pc_r[i] <= pc_in[i*PC_W +: PC_W];
                        if (halt_s[i]) begin
                            // Capture the pre-increment count of this edge.
                            node_done[i]                    <= 1'b1;
                            node_cycle[i*CNT_W +: CNT_W]    <= cycle_count;
                        end else begin
                            node_done[i]                    <= node_done[i];
                        end
                        if (stall_s[i] &&
                            (stall_count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                            stall_count[i*CNT_W +: CNT_W] <=
                                stall_count[i*CNT_W +: CNT_W] + CNT_W'(1);
                        end else begin
                            stall_count[i*CNT_W +: CNT_W] <=
                                stall_count[i*CNT_W +: CNT_W];
                        end
                    end
                    // Completion beats the watchdog on the same edge.
                    if (all_done_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= DRN_W'(DRAIN - 1);
                    end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
                        state_r <= ST_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_r == {DRN_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DRN_W'(1);
                    end
                end

                ST_DONE: begin
                    state_r <= ST_DONE;
                end

                ST_TIMEOUT: begin
                    state_r <= ST_TIMEOUT;
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is observed.

module tb_cmp_run_monitor;

    localparam int NODES = 4;
    localparam int W     = 32;
    localparam int DRN   = 5;
    localparam int TMO   = 50;
    localparam logic [31:0] HALT = 32'h00000000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic                    CLK;
    logic                    RESET;
    logic                    start;
    logic                    clear;
    logic [0:NODES-1]        node_mask;
    logic [0:NODES*W-1]      inst_in;
    logic [0:NODES*W-1]      pc_in;
    logic [2:0]              state;
    logic [W-1:0]            cycle_count;
    logic [0:NODES-1]        node_done;
    logic [0:NODES*W-1]      node_cycle;
    logic [0:NODES*W-1]      stall_count;
    logic                    done;
    logic                    timeout;

    logic [31:0] inst_a [NODES];
    logic [31:0] pc_a   [NODES];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    cmp_run_monitor #(
        .NODES(NODES), .PC_W(W), .INST_W(W), .CNT_W(W),
        .HALT_INST(HALT), .DRAIN(DRN), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .clear(clear),
        .node_mask(node_mask), .inst_in(inst_in), .pc_in(pc_in),
        .state(state), .cycle_count(cycle_count), .node_done(node_done),
        .node_cycle(node_cycle), .stall_count(stall_count),
        .done(done), .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        inst_in = '0;
        pc_in   = '0;
        for (int i = 0; i < NODES; i++) begin
            inst_in[i*W +: W] = inst_a[i];
            pc_in[i*W +: W]   = pc_a[i];
        end
    end

    function automatic logic [31:0] ncyc(input int i);
        return node_cycle[i*W +: W];
    endfunction

    function automatic logic [31:0] nstall(input int i);
        return stall_count[i*W +: W];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_all_inst(input logic [31:0] v);
        for (int i = 0; i < NODES; i++) inst_a[i] = v;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_start(input logic [0:NODES-1] m);
        node_mask = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b0; start = 1'b0; clear = 1'b0; node_mask = '0;
        for (int i = 0; i < NODES; i++) begin
            inst_a[i] = NOP;
            pc_a[i]   = 32'h0;
        end

        // ---------------- reset state ----------------
        step(); step();
        expect_val("rst_state", 32'd0);   observe(32'(state));
        expect_val("rst_cycle", 32'd0);   observe(cycle_count);
        expect_val("rst_done",  32'd0);   observe(32'(done));
        expect_val("rst_tmo",   32'd0);   observe(32'(timeout));
        expect_val("rst_ndone", 32'd0);   observe(32'(node_done));
        RESET = 1'b1;
        step();

        // ---------------- staggered halts, all nodes ----------------
        do_start(4'b1111);
        expect_val("s1_run", 32'd1);      observe(32'(state));
        for (int t = 1; t <= 40; t++) begin
            for (int i = 0; i < NODES; i++) begin
                inst_a[i] = (t == 10 * (i + 1)) ? HALT : NOP;
                pc_a[i]   = 32'(t * 4 + i * 1000);
            end
            if (t == 10) expect_val("s1_ndone_mid", 32'h8);
            if (t == 39) expect_val("s1_state39", 32'd1);
            step();
            if (t == 10) observe(32'(node_done));
            if (t == 39) observe(32'(state));
        end
        expect_val("s1_drain", 32'd2);    observe(32'(state));
        expect_val("s1_cycle", 32'd40);   observe(cycle_count);
        for (int i = 0; i < NODES; i++) begin
            expect_val("s1_ncyc",   32'(10 * (i + 1) - 1)); observe(ncyc(i));
            expect_val("s1_nstall", 32'd0);                 observe(nstall(i));
        end
        expect_val("s1_ndone", 32'hF);    observe(32'(node_done));
        set_all_inst(NOP);
        repeat (DRN - 1) step();
        expect_val("s1_still_drain", 32'd2); observe(32'(state));
        expect_val("s1_not_done",    32'd0); observe(32'(done));
        step();
        expect_val("s1_done_state", 32'd3);  observe(32'(state));
        expect_val("s1_done",       32'd1);  observe(32'(done));
        expect_val("s1_frozen",     32'd40); observe(cycle_count);

        // ---------------- partial mask, timeout ----------------
        pulse_clear();
        expect_val("clr_state", 32'd0);   observe(32'(state));
        expect_val("clr_cycle", 32'd0);   observe(cycle_count);
        expect_val("clr_done",  32'd0);   observe(32'(done));
        do_start(4'b1010);
        node_mask = 4'b0000;   // must not matter after the start edge
        for (int t = 1; t <= TMO; t++) begin
            inst_a[0] = (t == 10) ? HALT : NOP;
            inst_a[1] = HALT;
            inst_a[2] = NOP;
            inst_a[3] = HALT;
            pc_a[0] = 32'(t * 4);
            pc_a[1] = 32'h7;
            pc_a[2] = 32'(t * 8);
            pc_a[3] = 32'h7;
            if (t == TMO - 1) expect_val("s2_state49", 32'd1);
            step();
            if (t == TMO - 1) observe(32'(state));
        end
        expect_val("s2_tmo_state", 32'd4);     observe(32'(state));
        expect_val("s2_timeout",   32'd1);     observe(32'(timeout));
        expect_val("s2_done",      32'd0);     observe(32'(done));
        expect_val("s2_cycle",     32'(TMO));  observe(cycle_count);
        expect_val("s2_ndone",     32'h8);     observe(32'(node_done));
        expect_val("s2_ncyc0",     32'd9);     observe(ncyc(0));
        expect_val("s2_ncyc1",     32'd0);     observe(ncyc(1));
        expect_val("s2_stall1",    32'd0);     observe(nstall(1));
        expect_val("s2_stall3",    32'd0);     observe(nstall(3));
        do_start(4'b1111);
        step();
        expect_val("s2_start_ign", 32'd4);     observe(32'(state));
        expect_val("s2_frozen",    32'(TMO));  observe(cycle_count);

        // ---------------- stall counting ----------------
        pulse_clear();
        do_start(4'b1111);
        for (int t = 1; t <= 15; t++) begin
            for (int i = 0; i < NODES; i++) begin
                pc_a[i]   = 32'(t * 4 + i * 1000);
                inst_a[i] = (t == 15) ? HALT : NOP;
            end
            if (t <= 8)       pc_a[1] = 32'd100;
            else if (t <= 12) pc_a[1] = 32'(100 + 4 * t);
            else              pc_a[1] = 32'd999;
            inst_a[1] = (t == 12) ? HALT : NOP;
            step();
        end
        expect_val("s3_drain",  32'd2);  observe(32'(state));
        expect_val("s3_cycle",  32'd15); observe(cycle_count);
        expect_val("s3_stall0", 32'd0);  observe(nstall(0));
        expect_val("s3_stall1", 32'd7);  observe(nstall(1));
        expect_val("s3_stall2", 32'd0);  observe(nstall(2));
        expect_val("s3_stall3", 32'd0);  observe(nstall(3));
        expect_val("s3_ncyc1",  32'd11); observe(ncyc(1));
        expect_val("s3_ncyc0",  32'd14); observe(ncyc(0));

        // ------- halts on the timeout boundary, then reset mid-drain -------
        pulse_clear();
        do_start(4'b1111);
        for (int t = 1; t <= TMO; t++) begin
            for (int i = 0; i < NODES; i++) begin
                pc_a[i]   = 32'(t * 4 + i * 1000);
                inst_a[i] = (t == TMO) ? HALT : NOP;
            end
            step();
        end
        expect_val("s4_drain",  32'd2);        observe(32'(state));
        expect_val("s4_tmo",    32'd0);        observe(32'(timeout));
        expect_val("s4_cycle",  32'(TMO));     observe(cycle_count);
        expect_val("s4_ncyc3",  32'(TMO - 1)); observe(ncyc(3));
        set_all_inst(NOP);
        step(); step();
        RESET = 1'b0;
        #1;
        expect_val("s4_rst_state", 32'd0); observe(32'(state));
        expect_val("s4_rst_cycle", 32'd0); observe(cycle_count);
        expect_val("s4_rst_ndone", 32'd0); observe(32'(node_done));
        expect_val("s4_rst_ncyc3", 32'd0); observe(ncyc(3));
        #2;
        RESET = 1'b1;
        step();
        do_start(4'b1111);
        for (int t = 1; t <= 3; t++) begin
            set_all_inst((t == 3) ? HALT : NOP);
            step();
        end
        set_all_inst(NOP);
        expect_val("s4_re_drain", 32'd2); observe(32'(state));
        expect_val("s4_re_cycle", 32'd3); observe(cycle_count);
        expect_val("s4_re_ncyc0", 32'd2); observe(ncyc(0));
        repeat (DRN) step();
        expect_val("s4_re_done",  32'd1); observe(32'(done));

        // ---------------- clear and start together ----------------
        clear = 1'b1; start = 1'b1; node_mask = 4'b1111;
        step();
        clear = 1'b0; start = 1'b0;
        expect_val("s5_state", 32'd0); observe(32'(state));
        expect_val("s5_cycle", 32'd0); observe(cycle_count);
        expect_val("s5_done",  32'd0); observe(32'(done));
        step();
        expect_val("s5_idle",  32'd0); observe(32'(state));

        // ---------------- empty mask ----------------
        do_start(4'b0000);
        expect_val("s6_run",   32'd1); observe(32'(state));
        step();
        expect_val("s6_drain", 32'd2); observe(32'(state));
        expect_val("s6_cycle", 32'd1); observe(cycle_count);
        repeat (DRN - 1) step();
        expect_val("s6_still", 32'd2); observe(32'(state));
        step();
        expect_val("s6_done_state", 32'd3); observe(32'(state));
        expect_val("s6_done",       32'd1); observe(32'(done));
        expect_val("s6_cycle_fz",   32'd1); observe(cycle_count);
        expect_val("s6_ndone",      32'd0); observe(32'(node_done));

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
